// File: rtl/minv_mdiv_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | minv_mdiv_arb: round-robin arbiter/sequencer sharing one modular           |
// | inverse/division engine between two requesters.                            |
// | Optional watchdog abort: define MINV_ARB_TIMEOUT_EN.     Revision: 1.0     |
// +----------------------------------------------------------------------------+
module minv_mdiv_arb #(
   parameter int WIDTH          = 256,
   parameter int BEAT_W         = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [WIDTH-1:0]  req0_a,
   input  logic [WIDTH-1:0]  req0_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [WIDTH-1:0]  rsp0_data,
   output logic              rsp0_err,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [WIDTH-1:0]  req1_a,
   input  logic [WIDTH-1:0]  req1_b,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [WIDTH-1:0]  rsp1_data,
   output logic              rsp1_err,
   output logic              eng_start,
   output logic              eng_rst,
   output logic [WIDTH-1:0]  eng_a,
   output logic [WIDTH-1:0]  eng_b,
   input  logic              eng_idle,
   input  logic              eng_out_valid,
   output logic              eng_out_ready,
   input  logic [BEAT_W-1:0] eng_out_data,
   output logic              busy,
   output logic              grant_id
);

   localparam int         c_NBEATS    = WIDTH / BEAT_W;
   localparam logic [2:0] c_LAST_BEAT = 3'(c_NBEATS - 1);

   if (c_NBEATS != 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_param_check
      $error("minv_mdiv_arb: WIDTH/BEAT_W must be 8 and TIMEOUT_CYCLES in [2,65536]");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           r_state;
   logic             r_rr_last;
   logic             r_grant;
   logic             r_start;
   logic             r_out_ready;
   logic             r_busy;
   logic             r_rsp0_valid;
   logic             r_rsp1_valid;
   logic [2:0]       r_beat_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;

   logic w_can_grant;
   logic w_sel;
   logic w_req_fire;
   logic w_last_beat;
   logic w_rsp_fire;
   logic w_timeout;

   // Both valid: the requester not served last wins; otherwise the lone valid one.
   assign w_can_grant = (r_state == S_IDLE) && eng_idle;
   assign w_sel       = (req0_valid && req1_valid) ? ~r_rr_last : req1_valid;
   assign req0_ready  = w_can_grant && req0_valid && !w_sel;
   assign req1_ready  = w_can_grant && req1_valid && w_sel;
   assign w_req_fire  = req0_ready || req1_ready;
   assign w_last_beat = (r_state == S_RUN) && eng_out_valid && (r_beat_cnt == c_LAST_BEAT);
   assign w_rsp_fire  = (r_state == S_RESP) && (r_grant ? rsp1_ready : rsp0_ready);

   assign eng_start     = r_start;
   assign eng_a         = r_a;
   assign eng_b         = r_b;
   assign eng_out_ready = r_out_ready;
   assign busy          = r_busy;
   assign grant_id      = r_grant;
   assign rsp0_valid    = r_rsp0_valid;
   assign rsp1_valid    = r_rsp1_valid;
   assign rsp0_data     = r_result;
   assign rsp1_data     = r_result;

`ifdef MINV_ARB_TIMEOUT_EN
   logic [15:0] r_wdog;
   logic        r_err;

   // A final beat arriving on the timeout cycle wins over the abort.
   assign w_timeout = (r_state == S_RUN) && (r_wdog == 16'(TIMEOUT_CYCLES - 1)) && !w_last_beat;
   assign eng_rst   = w_timeout;
   assign rsp0_err  = r_err && !r_grant;
   assign rsp1_err  = r_err && r_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_req_fire) begin
            r_wdog <= '0;
         end else if (r_state == S_RUN) begin
            r_wdog <= r_wdog + 16'd1;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end else if (w_rsp_fire) begin
            r_err <= 1'b0;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
   assign eng_rst   = 1'b0;
   assign rsp0_err  = 1'b0;
   assign rsp1_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_rr_last    <= 1'b1;
         r_grant      <= 1'b0;
         r_start      <= 1'b0;
         r_out_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_beat_cnt   <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_result     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req_fire) begin
                  r_a       <= w_sel ? req1_a : req0_a;
                  r_b       <= w_sel ? req1_b : req0_b;
                  r_grant   <= w_sel;
                  r_rr_last <= w_sel;
                  r_start   <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= S_START;
               end
            end
            S_START: begin
               r_start     <= 1'b0;
               r_out_ready <= 1'b1;
               r_state     <= S_RUN;
            end
            S_RUN: begin
               if (eng_out_valid) begin
                  r_result[int'(r_beat_cnt)*BEAT_W +: BEAT_W] <= eng_out_data;
                  r_beat_cnt <= r_beat_cnt + 3'd1;
                  if (r_beat_cnt == c_LAST_BEAT) begin
                     r_out_ready  <= 1'b0;
                     r_rsp0_valid <= !r_grant;
                     r_rsp1_valid <= r_grant;
                     r_state      <= S_RESP;
                  end
               end else if (w_timeout) begin
                  r_beat_cnt   <= '0;
                  r_result     <= '0;
                  r_out_ready  <= 1'b0;
                  r_rsp0_valid <= !r_grant;
                  r_rsp1_valid <= r_grant;
                  r_state      <= S_RESP;
               end
            end
            S_RESP: begin
               if (w_rsp_fire) begin
                  r_rsp0_valid <= 1'b0;
                  r_rsp1_valid <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_minv_mdiv_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_minv_mdiv_arb: directed self-checking bench for minv_mdiv_arb.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_minv_mdiv_arb;
   localparam int WIDTH  = 256;
   localparam int BEAT_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req0_valid = 1'b0, req1_valid = 1'b0;
   logic              req0_ready, req1_ready;
   logic [WIDTH-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic              rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
   logic              rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [WIDTH-1:0]  rsp0_data, rsp1_data;
   logic              eng_start, eng_rst, eng_out_ready, busy, grant_id;
   logic [WIDTH-1:0]  eng_a, eng_b;
   logic              eng_idle = 1'b1, eng_out_valid = 1'b0;
   logic [BEAT_W-1:0] eng_out_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   minv_mdiv_arb #(.WIDTH(WIDTH), .BEAT_W(BEAT_W), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
      .eng_start(eng_start), .eng_rst(eng_rst), .eng_a(eng_a), .eng_b(eng_b),
      .eng_idle(eng_idle), .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready),
      .eng_out_data(eng_out_data), .busy(busy), .grant_id(grant_id)
   );

   task automatic check_val(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beats(input logic [WIDTH-1:0] res, input int n);
      for (int i = 0; i < n; i++) begin
         eng_out_valid = 1'b1;
         eng_out_data  = res[i*BEAT_W +: BEAT_W];
         step();
      end
      eng_out_valid = 1'b0;
      eng_out_data  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Caller drives valid/operands; waits for the grant, plays the engine, returns the result.
   task automatic run_op(input logic who, input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                         input logic [WIDTH-1:0] res, input int stall, input bit keep);
      int   n;
      logic rdy;
      logic stable;
      n = 0;
      #1;
      rdy = who ? req1_ready : req0_ready;
      while (!rdy && n < 50) begin
         step();
         #1;
         rdy = who ? req1_ready : req0_ready;
         n++;
      end
      check_val("req_ready", rdy, 1);
      check_val("other_ready", who ? req0_ready : req1_ready, 0);
      step();
      if (!keep) begin
         if (who) req1_valid = 1'b0;
         else     req0_valid = 1'b0;
      end
      check_val("eng_start_hi", eng_start, 1);
      check_val("grant_id", grant_id, who);
      check_val("eng_a", eng_a, ea);
      check_val("eng_b", eng_b, eb);
      check_val("busy_hi", busy, 1);
      step();
      check_val("eng_start_lo", eng_start, 0);
      check_val("out_ready_run", eng_out_ready, 1);
      send_beats(res, 8);
      check_val("rsp_valid", who ? rsp1_valid : rsp0_valid, 1);
      check_val("other_rsp_valid", who ? rsp0_valid : rsp1_valid, 0);
      check_val("rsp_data", who ? rsp1_data : rsp0_data, res);
      check_val("rsp_err", who ? rsp1_err : rsp0_err, 0);
      check_val("eng_rst", eng_rst, 0);
      check_val("out_ready_resp", eng_out_ready, 0);
      if (stall > 0) begin
         stable = 1'b1;
         for (int i = 0; i < stall; i++) begin
            step();
            if ((who ? rsp1_data : rsp0_data) !== res) stable = 1'b0;
            if ((who ? rsp1_valid : rsp0_valid) !== 1'b1) stable = 1'b0;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) stable = 1'b0;
            if ((who ? rsp0_valid : rsp1_valid) !== 1'b0) stable = 1'b0;
         end
         check_val("stall_stable", stable, 1);
      end
      if (who) rsp1_ready = 1'b1;
      else     rsp0_ready = 1'b1;
      step();
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      check_val("rsp_valid_lo", who ? rsp1_valid : rsp0_valid, 0);
      check_val("busy_lo", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] r_seq;
      logic [WIDTH-1:0] r_junk;
      for (int i = 0; i < 8; i++) r_seq[i*BEAT_W +: BEAT_W] = 32'(i + 1);
      r_junk = {8{32'hA5A5_5A5A}};

      // Reset state
      do_reset();
      check_val("rst_busy", busy, 0);
      check_val("rst_grant", grant_id, 0);
      check_val("rst_start", eng_start, 0);
      check_val("rst_eng_a", eng_a, 0);
      check_val("rst_out_ready", eng_out_ready, 0);
      check_val("rst_rsp0_valid", rsp0_valid, 0);
      check_val("rst_rsp1_data", rsp1_data, 0);
      check_val("rst_eng_rst", eng_rst, 0);

      // Test 1: req0 alone, engine busy blocks ready
      req0_a = 256'd3; req0_b = 256'd7; req0_valid = 1'b1;
      eng_idle = 1'b0;
      #1;
      check_val("eng_not_idle_ready", req0_ready, 0);
      eng_idle = 1'b1;
      run_op(1'b0, 256'd3, 256'd7, 256'd5, 0, 1'b0);

      // Tests 2/3: both valid from reset, grants alternate 0,1,0,1
      do_reset();
      req0_a = 256'h11; req0_b = 256'h22; req1_a = 256'h33; req1_b = 256'h44;
      req0_valid = 1'b1; req1_valid = 1'b1;
      run_op(1'b0, 256'h11, 256'h22, r_seq, 0, 1'b1);
      run_op(1'b1, 256'h33, 256'h44, {32'hFFFF_FFFF, 224'h0}, 0, 1'b1);
      run_op(1'b0, 256'h11, 256'h22, ~r_seq, 0, 1'b1);
      run_op(1'b1, 256'h33, 256'h44, 256'h1234_5678_9ABC, 0, 1'b0);
      req0_valid = 1'b0;
      check_val("seq_expected", r_seq,
                256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);

      // Test 4: rsp0 stalled 20 cycles while req1 waits
      do_reset();
      req0_a = 256'h101; req0_b = 256'h202; req1_a = 256'h303; req1_b = 256'h404;
      req0_valid = 1'b1; req1_valid = 1'b1;
      run_op(1'b0, 256'h101, 256'h202, 256'hCAFE, 20, 1'b0);
      #1;
      check_val("req1_ready_after_rsp", req1_ready, 1);
      run_op(1'b1, 256'h303, 256'h404, 256'hBEEF, 0, 1'b0);

      // Test 5: reset in RUN after 3 beats
      req1_a = 256'h55; req1_b = 256'h66; req1_valid = 1'b1;
      #1;
      check_val("t5_req1_ready", req1_ready, 1);
      step();
      req1_valid = 1'b0;
      step();
      send_beats(r_junk, 3);
      do_reset();
      check_val("t5_busy", busy, 0);
      check_val("t5_out_ready", eng_out_ready, 0);
      check_val("t5_eng_a", eng_a, 0);
      check_val("t5_eng_b", eng_b, 0);
      check_val("t5_grant", grant_id, 0);
      check_val("t5_rsp1_valid", rsp1_valid, 0);
      check_val("t5_rsp1_data", rsp1_data, 0);
      req1_a = 256'h77; req1_b = 256'h88; req1_valid = 1'b1;
      run_op(1'b1, 256'h77, 256'h88, r_seq, 0, 1'b0);

`ifdef MINV_ARB_TIMEOUT_EN
      // Test 6: engine silent, watchdog aborts at RUN cycle 63
      begin
         logic early;
         req0_a = 256'h9; req0_b = 256'hA; req0_valid = 1'b1;
         #1;
         check_val("t6_req0_ready", req0_ready, 1);
         step();
         req0_valid = 1'b0;
         step();
         early = 1'b0;
         for (int k = 0; k < 63; k++) begin
            if (eng_rst !== 1'b0 || rsp0_valid !== 1'b0) early = 1'b1;
            step();
         end
         check_val("t6_no_early_abort", early, 0);
         check_val("t6_eng_rst_hi", eng_rst, 1);
         check_val("t6_rsp_not_yet", rsp0_valid, 0);
         step();
         check_val("t6_eng_rst_lo", eng_rst, 0);
         check_val("t6_rsp_valid", rsp0_valid, 1);
         check_val("t6_rsp_err", rsp0_err, 1);
         check_val("t6_rsp_data", rsp0_data, 0);
         check_val("t6_rsp1_err", rsp1_err, 0);
         rsp0_ready = 1'b1;
         step();
         rsp0_ready = 1'b0;
         check_val("t6_err_cleared", rsp0_err, 0);
         check_val("t6_idle", busy, 0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
